// File: rtl/cache_write_ctrl.sv
// Write-path controller for the rasterizer cache: posted-write FIFO drained through LOOKUP/HIT/STALL.
// Optional feature: define WRITE_COALESCE_EN to merge same-address pushes into the newest entry.
module cache_write_ctrl #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned STALL_MAX = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic [ADDR_W-1:0]        upd_addr,
   input  logic [DATA_W-1:0]        upd_data,
   output logic [ADDR_W-1:0]        lkp_addr,
   input  logic                     lkp_hit,
   output logic                     fill_req,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [1:0]               write_state,
   output logic [$clog2(DEPTH):0]   buf_count,
   output logic                     stall_timeout
);

   localparam int unsigned PTR_W      = $clog2(DEPTH);
   localparam int unsigned CNT_W      = PTR_W + 1;
   localparam int unsigned SCNT_W     = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
   localparam int unsigned STALL_LAST = (STALL_MAX != 0) ? STALL_MAX - 1 : 0;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      HIT    = 2'b01,
      STALL  = 2'b10,
      LOOKUP = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q, newest;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;
   logic [ADDR_W-1:0]   addr_mem [DEPTH];
   logic [DATA_W-1:0]   data_mem [DEPTH];
   logic                push, pop, coalesce, alloc;

   assign upd_ready = (count_q < CNT_W'(DEPTH));
   assign push      = upd_valid && upd_ready;
   assign pop       = (state_q == HIT);
   assign newest    = wr_ptr_q - PTR_W'(1);

   // The head is only safe to merge into while nothing has started servicing it.
`ifdef WRITE_COALESCE_EN
   assign coalesce = push && (addr_mem[newest] == upd_addr) &&
                     ((count_q >= CNT_W'(2)) || ((count_q == CNT_W'(1)) && (state_q == IDLE)));
`else
   assign coalesce = 1'b0;
`endif
   assign alloc     = push && !coalesce;
   assign count_d   = count_q + CNT_W'(alloc) - CNT_W'(pop);

   // Next-state and stall-timer logic
   always_comb begin
      state_d       = state_q;
      scnt_d        = scnt_q;
      stall_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            scnt_d = '0;
            if (count_q != '0) state_d = LOOKUP;
         end
         LOOKUP: begin
            scnt_d  = '0;
            state_d = lkp_hit ? HIT : STALL;
         end
         STALL: begin
            if (lkp_hit) begin
               state_d = HIT;
               scnt_d  = '0;
            end else if ((STALL_MAX != 0) && (scnt_q == SCNT_W'(STALL_LAST))) begin
               state_d       = LOOKUP;
               stall_timeout = 1'b1;
               scnt_d        = '0;
            end else begin
               scnt_d = scnt_q + SCNT_W'(1);
            end
         end
         HIT: begin
            scnt_d  = '0;
            state_d = (count_d != '0) ? LOOKUP : IDLE;
         end
         default: begin
            state_d = IDLE;
            scnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         scnt_q   <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         count_q <= count_d;
         if (alloc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Entry storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_mem[wr_ptr_q] <= upd_addr;
         data_mem[wr_ptr_q] <= upd_data;
      end else if (coalesce) begin
         data_mem[newest] <= upd_data;
      end
   end

   assign lkp_addr    = addr_mem[rd_ptr_q];
   assign wr_addr     = addr_mem[rd_ptr_q];
   assign wr_data     = data_mem[rd_ptr_q];
   assign wr_en       = (state_q == HIT);
   assign fill_req    = (state_q == STALL);
   assign write_state = state_q;
   assign buf_count   = count_q;

endmodule
